// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock; optional stall counter (STALL_COUNT_EN).
// Latency: ID inputs appear on ID_EX_* one clock after capture; stall is combinational from ID inputs.
// Backpressure: stall holds PC and IF/ID while bubbles go to EX; flush overrides stall and squashes the captured instruction.
//
// Ports: clk/rst_n (async active-low), flush, ID_* decoded instruction in,
//        ID_EX_* registered copies out, stall out, stall_count out (STALL_COUNT_EN only).
// Parameters: DATA_W operand width, ALUOP_W ALU opcode width,
//             LOAD_STALL_CYC bubbles per load-use hazard (1..7).
module id_ex_stage #(
    parameter int DATA_W         = 32,
    parameter int ALUOP_W        = 3,
    parameter int LOAD_STALL_CYC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               ID_Valid,
    input  logic [4:0]         ID_Rs,
    input  logic [4:0]         ID_Rt,
    input  logic [4:0]         ID_Rd,
    input  logic               ID_UsesRt,
    input  logic               ID_RegWrite,
    input  logic               ID_MemRead,
    input  logic               ID_MemWrite,
    input  logic               ID_MemToReg,
    input  logic               ID_ALUSrc,
    input  logic               ID_RegDst,
    input  logic [ALUOP_W-1:0] ID_ALUOp,
    input  logic [DATA_W-1:0]  ID_ReadData1,
    input  logic [DATA_W-1:0]  ID_ReadData2,
    input  logic [DATA_W-1:0]  ID_Imm,
    output logic               ID_EX_Valid,
    output logic [4:0]         ID_EX_Rs,
    output logic [4:0]         ID_EX_Rt,
    output logic [4:0]         ID_EX_Rd,
    output logic               ID_EX_UsesRt,
    output logic               ID_EX_RegWrite,
    output logic               ID_EX_MemRead,
    output logic               ID_EX_MemWrite,
    output logic               ID_EX_MemToReg,
    output logic               ID_EX_ALUSrc,
    output logic               ID_EX_RegDst,
    output logic [ALUOP_W-1:0] ID_EX_ALUOp,
    output logic [DATA_W-1:0]  ID_EX_ReadData1,
    output logic [DATA_W-1:0]  ID_EX_ReadData2,
    output logic [DATA_W-1:0]  ID_EX_Imm,
`ifdef STALL_COUNT_EN
    output logic [31:0]        stall_count,
`endif
    output logic               stall
);

    typedef struct packed {
        logic               valid;
        logic [4:0]         rs;
        logic [4:0]         rt;
        logic [4:0]         rd;
        logic               uses_rt;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic               reg_dst;
        logic [ALUOP_W-1:0] alu_op;
        logic [DATA_W-1:0]  read_data1;
        logic [DATA_W-1:0]  read_data2;
        logic [DATA_W-1:0]  imm;
    } idex_t;

    typedef enum logic {RUN, HOLD} state_t;

    // HOLD covers the bubbles after the first one, so it starts at LOAD_STALL_CYC-2.
    localparam logic [2:0] CNT_INIT = 3'((LOAD_STALL_CYC > 1) ? (LOAD_STALL_CYC - 2) : 0);

    idex_t  pipe_q, pipe_d, id_bundle;
    state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic haz;

    assign id_bundle = {ID_Valid, ID_Rs, ID_Rt, ID_Rd, ID_UsesRt, ID_RegWrite,
                        ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_RegDst,
                        ID_ALUOp, ID_ReadData1, ID_ReadData2, ID_Imm};

    always_comb begin
        // Loaded value in EX is not yet available for forwarding to the ID instruction.
        haz = ID_Valid & pipe_q.valid & pipe_q.mem_read & (pipe_q.rt != 5'd0) &
              ((pipe_q.rt == ID_Rs) | (ID_UsesRt & (pipe_q.rt == ID_Rt)));
        // HOLD stalls regardless of haz; flush always releases the front end.
        stall   = ~flush & ((state_q == HOLD) | haz);
        state_d = state_q;
        cnt_d   = cnt_q;
        pipe_d  = ID_Valid ? id_bundle : '0;
        if (flush) begin
            pipe_d  = '0;
            state_d = RUN;
            cnt_d   = 3'd0;
        end else if (state_q == HOLD) begin
            pipe_d = '0;
            if (cnt_q == 3'd0) state_d = RUN;
            else               cnt_d   = cnt_q - 3'd1;
        end else if (haz) begin
            pipe_d = '0;
            cnt_d  = CNT_INIT;
            if (LOAD_STALL_CYC > 1) state_d = HOLD;
        end
    end

`ifdef STALL_COUNT_EN
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 32'hFFFF_FFFF)) stall_count_d = stall_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_count_q <= 32'd0;
        else        stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q  <= '0;
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            pipe_q  <= pipe_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ID_EX_Valid     = pipe_q.valid;
    assign ID_EX_Rs        = pipe_q.rs;
    assign ID_EX_Rt        = pipe_q.rt;
    assign ID_EX_Rd        = pipe_q.rd;
    assign ID_EX_UsesRt    = pipe_q.uses_rt;
    assign ID_EX_RegWrite  = pipe_q.reg_write;
    assign ID_EX_MemRead   = pipe_q.mem_read;
    assign ID_EX_MemWrite  = pipe_q.mem_write;
    assign ID_EX_MemToReg  = pipe_q.mem_to_reg;
    assign ID_EX_ALUSrc    = pipe_q.alu_src;
    assign ID_EX_RegDst    = pipe_q.reg_dst;
    assign ID_EX_ALUOp     = pipe_q.alu_op;
    assign ID_EX_ReadData1 = pipe_q.read_data1;
    assign ID_EX_ReadData2 = pipe_q.read_data2;
    assign ID_EX_Imm       = pipe_q.imm;

endmodule
